// File: rtl/pc_npc_if.sv
// Control-unit <-> PC/nPC unit bundle: retire/branch/trap requests in,
// program-counter state and mode flags out.
interface pc_npc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             advance;
  logic             br_taken;
  logic             annul;
  logic [WIDTH-1:0] target;
  logic             trap;
  logic [WIDTH-1:0] trap_vector;
  logic             ret;
  logic             ret_mode;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] npc;
  logic [WIDTH-1:0] saved_pc;
  logic [WIDTH-1:0] saved_npc;
  logic             delay_slot;
  logic             in_trap;
  logic             error;

  modport master (
    output advance, br_taken, annul, target, trap, trap_vector, ret, ret_mode,
    input  pc, npc, saved_pc, saved_npc, delay_slot, in_trap, error
  );

  modport slave (
    input  advance, br_taken, annul, target, trap, trap_vector, ret, ret_mode,
    output pc, npc, saved_pc, saved_npc, delay_slot, in_trap, error
  );
endinterface

// File: rtl/pc_npc_unit.sv
// SPARC PC/nPC register pair: delayed control transfer with annul, trap
// entry/return with saved PC/nPC, and a halting error mode on nested traps.
module pc_npc_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      INC      = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     reset,
  pc_npc_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DELAY, TRAP, ERROR} state_t;

  state_t           state_p0, state_nxt;
  logic [WIDTH-1:0] pc_p0, npc_p0, spc_p0, snpc_p0;
  logic [WIDTH-1:0] pc_nxt, npc_nxt, spc_nxt, snpc_nxt;

  // Address plus n instructions, silently wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] fwd(input logic [WIDTH-1:0] a,
                                           input int unsigned      n);
    return a + WIDTH'(n * INC);
  endfunction

  // A trap handler keeps its mode across ordinary advances.
  function automatic state_t settle(input state_t cur, input state_t want);
    return (cur == TRAP) ? TRAP : want;
  endfunction

  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    npc_nxt   = npc_p0;
    spc_nxt   = spc_p0;
    snpc_nxt  = snpc_p0;
    if (state_p0 == ERROR) begin
      state_nxt = ERROR;
    end else if (bus.trap) begin
      if (state_p0 == TRAP) begin
        state_nxt = ERROR;
      end else begin
        spc_nxt   = pc_p0;
        snpc_nxt  = npc_p0;
        pc_nxt    = bus.trap_vector;
        npc_nxt   = fwd(bus.trap_vector, 1);
        state_nxt = TRAP;
      end
    end else if (bus.advance && bus.ret && state_p0 == TRAP) begin
      if (bus.ret_mode) begin
        pc_nxt  = snpc_p0;
        npc_nxt = fwd(snpc_p0, 1);
      end else begin
        pc_nxt  = spc_p0;
        npc_nxt = snpc_p0;
      end
      state_nxt = RUN;
    end else if (bus.advance) begin
      unique case ({bus.br_taken, bus.annul})
        2'b00: begin
          pc_nxt    = npc_p0;
          npc_nxt   = fwd(npc_p0, 1);
          state_nxt = settle(state_p0, RUN);
        end
        2'b10: begin
          pc_nxt    = npc_p0;
          npc_nxt   = bus.target;
          state_nxt = settle(state_p0, DELAY);
        end
        2'b11: begin
          pc_nxt    = bus.target;
          npc_nxt   = fwd(bus.target, 1);
          state_nxt = settle(state_p0, RUN);
        end
        default: begin
          pc_nxt    = fwd(npc_p0, 1);
          npc_nxt   = fwd(npc_p0, 2);
          state_nxt = settle(state_p0, RUN);
        end
      endcase
    end
  end

  // ---- register stage p0 ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= RUN;
      pc_p0    <= RESET_PC;
      npc_p0   <= fwd(RESET_PC, 1);
      spc_p0   <= '0;
      snpc_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      pc_p0    <= pc_nxt;
      npc_p0   <= npc_nxt;
      spc_p0   <= spc_nxt;
      snpc_p0  <= snpc_nxt;
    end
  end

  assign bus.pc         = pc_p0;
  assign bus.npc        = npc_p0;
  assign bus.saved_pc   = spc_p0;
  assign bus.saved_npc  = snpc_p0;
  assign bus.delay_slot = (state_p0 == DELAY);
  assign bus.in_trap    = (state_p0 == TRAP);
  assign bus.error      = (state_p0 == ERROR);

endmodule

// File: doc/pc_npc_unit.md
# pc_npc_unit

Parametrised PC/nPC register pair for the SPARC datapath, replacing the standalone nPC register. It holds both program counters, implements delayed control transfer (delay slot, annul), trap entry with saved PC/nPC, trap return (retry/done), and an error-mode halt on nested traps. It sits between the control unit and the instruction-fetch address mux.

## Interface
- WIDTH, 32, address width of all PC-related buses
- INC, 4, sequential increment (instruction size in bytes)
- RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+INC

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- advance  in  1  instruction retires this cycle; qualifies br_taken, annul, ret
- br_taken  in  1  retiring instruction is a taken control transfer
- annul  in  1  annul bit of the retiring branch
- target  in  WIDTH  branch/jump target address
- trap  in  1  trap request (not qualified by advance)
- trap_vector  in  WIDTH  handler address for trap
- ret  in  1  trap return
- ret_mode  in  1  0 = retry (re-execute trapped instr), 1 = done (skip it)
- pc  out  WIDTH  current PC
- npc  out  WIDTH  next PC
- saved_pc  out  WIDTH  PC captured at trap entry
- saved_npc  out  WIDTH  nPC captured at trap entry
- delay_slot  out  1  instruction at pc is a delay-slot instruction
- in_trap  out  1  trap handler active
- error  out  1  error mode, unit halted

## Operation
- FSM states: RUN, DELAY, TRAP, ERROR. delay_slot=(state==DELAY); in_trap=(state==TRAP); error=(state==ERROR).
- Priority per edge: reset > ERROR hold > trap > ret > advance ops > hold.
- reset: pc=RESET_PC, npc=RESET_PC+INC, saved_pc=saved_npc=0, state=RUN. Applies mid-trap and in ERROR.
- ERROR: all registers frozen; all inputs ignored until reset.
- trap in RUN/DELAY: saved_pc<=pc, saved_npc<=npc, pc<=trap_vector, npc<=trap_vector+INC, state<=TRAP. Overrides simultaneous advance/br_taken/ret.
- trap in TRAP: state<=ERROR; pc/npc/saved regs unchanged.
- ret (with advance, in TRAP only): retry: pc<=saved_pc, npc<=saved_npc; done: pc<=saved_npc, npc<=saved_npc+INC; state<=RUN. ret outside TRAP is ignored and the cycle is handled as a normal advance op.
- advance ops (advance=1, no trap, no valid ret), by (br_taken, annul):
  - (0,0) sequential: pc<=npc, npc<=npc+INC; state<=RUN.
  - (1,0) delayed transfer: pc<=npc, npc<=target; state<=DELAY (or TRAP if already TRAP: state preserved when in TRAP).
  - (1,1) annulled taken (ba,a): pc<=target, npc<=target+INC; delay slot skipped; state<=RUN.
  - (0,1) untaken annulled: pc<=npc+INC, npc<=npc+2*INC; state<=RUN.
- In TRAP, advance ops update pc/npc as above but state stays TRAP; delay_slot is 0 in TRAP.
- Branch in DELAY (DCTI couple): handled per table; pc<=old npc (the first target).
- advance=0 with no trap: all registers hold.
- Arithmetic modulo 2^WIDTH; wrap-around is silent. target/trap_vector used unaltered (no alignment check).

## Timing
- All outputs registered; updates visible one cycle after the sampling edge.
- No combinational path from any input to any output.
- trap is accepted in the cycle it is asserted; caller must deassert next cycle (a held trap in TRAP escalates to ERROR).
- Single-cycle latency for every operation; no multi-cycle sequences.

## Test plan
- Reset, WIDTH=32, RESET_PC=0: pc=0, npc=4, state RUN; 3 sequential advances -> pc=12, npc=16; advance=0 for 2 cycles -> unchanged.
- pc=8, npc=12, br_taken=1 annul=0 target=0x100 -> pc=12, npc=0x100, delay_slot=1; next sequential -> pc=0x100, npc=0x104, delay_slot=0.
- pc=8, npc=12: (1,1) target=0x200 -> pc=0x200, npc=0x204; separately (0,1) -> pc=16, npc=20.
- pc=0x40, npc=0x44, trap with trap_vector=0x800 and simultaneous br_taken -> pc=0x800, npc=0x804, saved 0x40/0x44, in_trap=1; ret retry -> pc=0x40, npc=0x44; repeat with done -> pc=0x44, npc=0x48.
- Second trap while in_trap=1 -> error=1, all registers frozen over 5 cycles of random stimulus; reset -> pc=0, npc=4, error=0.
- WIDTH=8: npc=0xFC sequential -> pc=0xFC, npc=0x00 (wrap); reset asserted mid-trap -> pc=RESET_PC, in_trap=0.
